// File: rtl/ula_sequencer_pkg.sv
// Shared definitions for the TP2 ULA sequencer: widths, opcodes, field
// positions, FSM encoding and instruction field extraction helpers.
package ula_defs;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int REP_W  = 7;
  localparam int IMM_W  = 9;

  localparam int OPC_LSB = 13;
  localparam int RX_LSB  = 10;
  localparam int RY_LSB  = 7;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_REP  = 3'b111;

  localparam logic [2:0] OPSEL_PASS = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WB      = 2'd2,
    REP_CHK = 2'd3
  } state_t;

  function automatic logic [2:0] f_opcode(input logic [DATA_W-1:0] w);
    return w[OPC_LSB +: 3];
  endfunction

  function automatic logic [REG_AW-1:0] f_rx(input logic [DATA_W-1:0] w);
    return w[RX_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] f_ry(input logic [DATA_W-1:0] w);
    return w[RY_LSB +: REG_AW];
  endfunction

  function automatic logic [DATA_W-1:0] f_imm(input logic [DATA_W-1:0] w);
    return {{(DATA_W-IMM_W){1'b0}}, w[IMM_W-1:0]};
  endfunction

  function automatic logic [REP_W-1:0] f_count(input logic [DATA_W-1:0] w);
    return w[REP_W-1:0];
  endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// Instruction handshake plus register-file/ULA control bundle of the sequencer.
interface ula_sequencer_if;
  import ula_defs::*;

  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [REG_AW-1:0] rx_addr;
  logic [REG_AW-1:0] ry_addr;
  logic [2:0]        op_select;
  logic [DATA_W-1:0] imm_value;
  logic              imm_sel;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic              out_en;
  logic              busy;
  logic              illegal;

  modport master (
    output instr, instr_valid,
    input  instr_ready, rx_addr, ry_addr, op_select, imm_value, imm_sel,
           wr_en, wr_addr, out_en, busy, illegal
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, rx_addr, ry_addr, op_select, imm_value, imm_sel,
           wr_en, wr_addr, out_en, busy, illegal
  );

endinterface

// File: rtl/ula_sequencer_decode.sv
// Combinational opcode classification for the ULA sequencer.
module ula_decode
  import ula_defs::*;
(
  input  logic [2:0] opcode,
  output logic       is_alu,
  output logic       is_out,
  output logic       is_ldi,
  output logic       is_rep,
  output logic       is_illegal,
  output logic       writes_reg
);

  // Opcode class decode; 011 and 110 fall to the illegal default.
  always_comb begin
    is_alu     = 1'b0;
    is_out     = 1'b0;
    is_ldi     = 1'b0;
    is_rep     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NAND: is_alu = 1'b1;
      OP_OUT:                  is_out = 1'b1;
      OP_LDI:                  is_ldi = 1'b1;
      OP_REP:                  is_rep = 1'b1;
      default:                 is_illegal = 1'b1;
    endcase
    writes_reg = is_alu | is_ldi;
  end

endmodule

// File: rtl/ula_sequencer.sv
// Multi-cycle sequencer for the TP2 ULA and register file, including the
// rep opcode that replays the last executed instruction a counted number of times.
module ula_sequencer
  import ula_defs::*;
(
  input  logic            clock,
  input  logic            reset,
  ula_sequencer_if.slave  bus
);

  state_t            state_r;
  logic [DATA_W-1:0] exec_r;
  logic [DATA_W-1:0] last_r;
  logic              have_last_r;
  logic              in_rep_r;
  logic [REP_W-1:0]  count_r;

  logic              exec_rep_r;
  logic              exec_wr_r;
  logic              exec_ldi_r;
  logic              exec_out_r;

  logic              instr_ready_r;
  logic [REG_AW-1:0] rx_addr_r;
  logic [REG_AW-1:0] ry_addr_r;
  logic [2:0]        op_select_r;
  logic [DATA_W-1:0] imm_value_r;
  logic              imm_sel_r;
  logic              wr_en_r;
  logic [REG_AW-1:0] wr_addr_r;
  logic              out_en_r;
  logic              busy_r;
  logic              illegal_r;

  logic              load_s;
  logic [DATA_W-1:0] load_word_s;
  logic [2:0]        load_opc_s;
  logic              dec_alu_s;
  logic              dec_out_s;
  logic              dec_ldi_s;
  logic              dec_rep_s;
  logic              dec_ill_s;
  logic              dec_wr_s;

  // Select the word entering EXEC: a fresh instruction from IDLE or the replayed one from REP_CHK.
  always_comb begin
    load_s      = 1'b0;
    load_word_s = last_r;
    if (state_r == IDLE) begin
      load_word_s = bus.instr;
      load_s      = bus.instr_valid & instr_ready_r;
    end else if (state_r == REP_CHK) begin
      load_word_s = last_r;
      load_s      = have_last_r & (count_r != {REP_W{1'b0}});
    end else begin
      load_word_s = last_r;
      load_s      = 1'b0;
    end
    load_opc_s = f_opcode(load_word_s);
  end

  ula_decode u_decode (
    .opcode     (load_opc_s),
    .is_alu     (dec_alu_s),
    .is_out     (dec_out_s),
    .is_ldi     (dec_ldi_s),
    .is_rep     (dec_rep_s),
    .is_illegal (dec_ill_s),
    .writes_reg (dec_wr_s)
  );

  // Sequencer FSM with registered control outputs, latches and rep counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      exec_r        <= {DATA_W{1'b0}};
      last_r        <= {DATA_W{1'b0}};
      have_last_r   <= 1'b0;
      in_rep_r      <= 1'b0;
      count_r       <= {REP_W{1'b0}};
      exec_rep_r    <= 1'b0;
      exec_wr_r     <= 1'b0;
      exec_ldi_r    <= 1'b0;
      exec_out_r    <= 1'b0;
      instr_ready_r <= 1'b1;
      rx_addr_r     <= {REG_AW{1'b0}};
      ry_addr_r     <= {REG_AW{1'b0}};
      op_select_r   <= OPSEL_PASS;
      imm_value_r   <= {DATA_W{1'b0}};
      imm_sel_r     <= 1'b0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {REG_AW{1'b0}};
      out_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r       <= EXEC;
            instr_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end
        end
        EXEC: begin
          illegal_r <= 1'b0;
          if (illegal_r) begin
            state_r       <= IDLE;
            in_rep_r      <= 1'b0;
            instr_ready_r <= 1'b1;
            busy_r        <= 1'b0;
          end else if (exec_rep_r) begin
            state_r  <= REP_CHK;
            count_r  <= f_count(exec_r);
            in_rep_r <= 1'b1;
          end else begin
            state_r   <= WB;
            wr_en_r   <= exec_wr_r;
            wr_addr_r <= rx_addr_r;
            imm_sel_r <= exec_ldi_r;
            out_en_r  <= exec_out_r;
          end
        end
        WB: begin
          wr_en_r     <= 1'b0;
          out_en_r    <= 1'b0;
          imm_sel_r   <= 1'b0;
          last_r      <= exec_r;
          have_last_r <= 1'b1;
          if (in_rep_r) begin
            state_r <= REP_CHK;
          end else begin
            state_r       <= IDLE;
            instr_ready_r <= 1'b1;
            busy_r        <= 1'b0;
          end
        end
        REP_CHK: begin
          if (load_s) begin
            state_r <= EXEC;
            count_r <= count_r - {{(REP_W-1){1'b0}}, 1'b1};
          end else begin
            state_r       <= IDLE;
            in_rep_r      <= 1'b0;
            instr_ready_r <= 1'b1;
            busy_r        <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          instr_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
      endcase

      // Operand fields are captured on entry to EXEC and held through WB.
      if (load_s) begin
        exec_r      <= load_word_s;
        rx_addr_r   <= f_rx(load_word_s);
        ry_addr_r   <= f_ry(load_word_s);
        op_select_r <= dec_alu_s ? load_opc_s : OPSEL_PASS;
        imm_value_r <= f_imm(load_word_s);
        illegal_r   <= dec_ill_s;
        exec_rep_r  <= dec_rep_s;
        exec_wr_r   <= dec_wr_s;
        exec_ldi_r  <= dec_ldi_s;
        exec_out_r  <= dec_out_s;
      end
    end
  end

  assign bus.instr_ready = instr_ready_r;
  assign bus.rx_addr     = rx_addr_r;
  assign bus.ry_addr     = ry_addr_r;
  assign bus.op_select   = op_select_r;
  assign bus.imm_value   = imm_value_r;
  assign bus.imm_sel     = imm_sel_r;
  assign bus.wr_en       = wr_en_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.out_en      = out_en_r;
  assign bus.busy        = busy_r;
  assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed self-checking bench for ula_sequencer: plain ops, ldi, out, rep runs,
// illegal opcodes and reset in the middle of a rep run.
module tb_ula_sequencer;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  ula_sequencer_if bus_if ();

  ula_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a word for one cycle; returns at the sample point of cycle T+1.
  task automatic send(input logic [15:0] w);
    bus_if.instr       = w;
    bus_if.instr_valid = 1'b1;
    tick();
    bus_if.instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int offs[3];
  int np;
  int n_out;
  int n_strobe;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus_if.instr       = 16'h0500;
    bus_if.instr_valid = 1'b1;
    tick();
    tick();
    // reset wins over a simultaneous valid instruction
    check_eq("rst_ready", bus_if.instr_ready, 1);
    check_eq("rst_busy", bus_if.busy, 0);
    check_eq("rst_opsel", bus_if.op_select, 3'b100);
    check_eq("rst_wr_en", bus_if.wr_en, 0);
    check_eq("rst_rx", bus_if.rx_addr, 0);
    check_eq("rst_imm", bus_if.imm_value, 0);
    bus_if.instr_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_eq("rst_idle_busy", bus_if.busy, 0);

    // add r1,r2
    send(16'h0500);
    check_eq("add_opsel", bus_if.op_select, 3'b000);
    check_eq("add_rx", bus_if.rx_addr, 1);
    check_eq("add_ry", bus_if.ry_addr, 2);
    check_eq("add_busy", bus_if.busy, 1);
    check_eq("add_ready_t1", bus_if.instr_ready, 0);
    check_eq("add_wr_t1", bus_if.wr_en, 0);
    tick();
    check_eq("add_wr_en", bus_if.wr_en, 1);
    check_eq("add_wr_addr", bus_if.wr_addr, 1);
    check_eq("add_imm_sel", bus_if.imm_sel, 0);
    check_eq("add_out_en", bus_if.out_en, 0);
    check_eq("add_opsel_wb", bus_if.op_select, 3'b000);
    tick();
    check_eq("add_ready_t3", bus_if.instr_ready, 1);
    check_eq("add_wr_t3", bus_if.wr_en, 0);
    check_eq("add_busy_t3", bus_if.busy, 0);

    // ldi r3,0x1F
    send(16'hAC1F);
    check_eq("ldi_opsel", bus_if.op_select, 3'b100);
    tick();
    check_eq("ldi_imm_sel", bus_if.imm_sel, 1);
    check_eq("ldi_imm_value", bus_if.imm_value, 16'h001F);
    check_eq("ldi_wr_en", bus_if.wr_en, 1);
    check_eq("ldi_wr_addr", bus_if.wr_addr, 3);
    tick();

    // out r5
    send(16'h9400);
    check_eq("out_rx", bus_if.rx_addr, 5);
    check_eq("out_opsel", bus_if.op_select, 3'b100);
    check_eq("out_wr_t1", bus_if.wr_en, 0);
    tick();
    check_eq("out_out_en", bus_if.out_en, 1);
    check_eq("out_wr_t2", bus_if.wr_en, 0);
    check_eq("out_rx_wb", bus_if.rx_addr, 5);
    tick();
    check_eq("out_out_off", bus_if.out_en, 0);
    check_eq("out_ready", bus_if.instr_ready, 1);

    // add then rep 3: replays at offsets 4, 7, 10 after the rep is accepted
    send(16'h0500);
    tick();
    tick();
    send(16'hE003);
    np = 0;
    n_out = 0;
    for (int k = 1; k <= 13; k++) begin
      if (bus_if.wr_en) begin
        if (np < 3) offs[np] = k;
        np++;
        check_eq("rep_wr_addr", bus_if.wr_addr, 1);
      end
      if (bus_if.out_en) n_out++;
      if (k == 11) check_eq("rep_busy_last", bus_if.busy, 1);
      if (k == 12) check_eq("rep_busy_fall", bus_if.busy, 0);
      tick();
    end
    check_eq("rep_pulse_count", np, 3);
    check_eq("rep_pulse0", offs[0], 4);
    check_eq("rep_pulse1", offs[1], 7);
    check_eq("rep_pulse2", offs[2], 10);
    check_eq("rep_no_out", n_out, 0);

    // illegal opcode 011
    send(16'h6000);
    check_eq("ill_pulse", bus_if.illegal, 1);
    check_eq("ill_wr_t1", bus_if.wr_en, 0);
    tick();
    check_eq("ill_pulse_end", bus_if.illegal, 0);
    check_eq("ill_ready", bus_if.instr_ready, 1);
    check_eq("ill_wr_t2", bus_if.wr_en | bus_if.out_en, 0);

    // rep 5 straight after reset has nothing to replay
    do_reset();
    send(16'hE005);
    n_strobe = 0;
    for (int k = 1; k <= 3; k++) begin
      if (bus_if.wr_en || bus_if.out_en || bus_if.illegal) n_strobe++;
      if (k == 3) begin
        check_eq("rep0_ready", bus_if.instr_ready, 1);
        check_eq("rep0_busy", bus_if.busy, 0);
      end
      tick();
    end
    check_eq("rep0_no_strobe", n_strobe, 0);

    // reset during the EXEC of the second repetition
    send(16'h0500);
    tick();
    tick();
    send(16'hE003);
    for (int k = 1; k < 6; k++) tick();
    check_eq("mid_busy", bus_if.busy, 1);
    check_eq("mid_rx", bus_if.rx_addr, 1);
    reset = 1'b1;
    tick();
    check_eq("mid_wr_en", bus_if.wr_en, 0);
    check_eq("mid_busy_rst", bus_if.busy, 0);
    check_eq("mid_ready_rst", bus_if.instr_ready, 1);
    check_eq("mid_opsel_rst", bus_if.op_select, 3'b100);
    check_eq("mid_rx_rst", bus_if.rx_addr, 0);
    reset = 1'b0;
    n_strobe = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_if.wr_en || bus_if.out_en) n_strobe++;
      tick();
    end
    check_eq("mid_no_wr_after", n_strobe, 0);
    send(16'hE003);
    n_strobe = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus_if.wr_en || bus_if.out_en) n_strobe++;
      if (k == 3) check_eq("mid_rep_idle", bus_if.busy, 0);
      tick();
    end
    check_eq("mid_rep_noop", n_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
